robot_route_sequencer: RTL and testbench
========================================

// Module: robot_route_sequencer
// PURPOSE
//  Command sequencer in front of the robot core. Buffers queued motion commands and powers the motors up and down.
//  Issues one move code per command on the robot move bus, then holds STAY for a settle window.
//  Tracks grid position and heading, and refuses moves that would leave the grid or hit a front obstacle.
// PARAMETERS
//  DEPTH       8   command FIFO entries (power of 2, >=2)
//  GRID        7   grid side; legal coordinates 1..GRID
//  X0          5   x coordinate after reset
//  Y0          1   y coordinate after reset
//  SETTLE_CYC  1   STAY cycles after each issued or refused command (>=1)
//  PWR_TMO     16  max cycles waiting for a motor_status edge
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_i           in   1   reset, asynchronous, active-high
//  enable_i        in   1   1 = run queue; 0 = pause after current command
//  cmd_valid_i     in   1   command offered
//  cmd_i           in   2   00 FWD, 01 BWD, 10 LEFT, 11 RIGHT
//  cmd_ready_o     out  1   command accepted when valid&ready
//  motor_on_o      out  1   to robot motor_on_i
//  motor_status_i  in   1   from robot motor_status_o
//  move_o          out  3   to robot move_i: STAY 000, FWD 111, BWD 011, LEFT 101, RIGHT 110
//  tracker_i       in   1   from robot tracker_status_o (obstacle ahead)
//  pos_x_o         out  3   current x
//  pos_y_o         out  3   current y
//  heading_o       out  2   00 W, 01 N, 10 E, 11 S
//  busy_o          out  1   state != IDLE
//  blocked_o       out  1   1-cycle pulse: command refused
//  fault_o         out  1   sticky power fault; cleared only by reset
//  count_o         out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  Reset (async):
//   - move_o=000, motor_on_o=0, blocked_o=0, fault_o=0, busy_o=0
//   - FIFO emptied, count_o=0; pos=(X0,Y0), heading=01; state IDLE
//   - Reset mid-move is allowed: move_o returns to 000 immediately.
//  FIFO:
//   - cmd_ready_o = (count_o<DEPTH) && !fault_o
//   - Push and pop in the same cycle leave count unchanged.
//   - No push when full. Pop happens only in FETCH.
//  All outputs are registered. move_o is 000 in every state except MOVE.
//  States:
//   - IDLE: if enable_i && count_o!=0, assert motor_on_o and go to PWRUP.
//   - PWRUP: wait for motor_status_i=1, then go to FETCH. After PWR_TMO cycles: set fault_o, drop motor_on_o, flush FIFO, go to IDLE.
//   - FETCH (1 cycle): pop head and evaluate it.
//     - FWD is refused if tracker_i=1 or the next cell is outside 1..GRID.
//     - BWD is refused if the rear cell is outside 1..GRID.
//     - LEFT and RIGHT are never refused.
//     - Legal command: go to MOVE. pos/heading update on this same edge.
//     - Refused command: blocked_o=1 for one cycle, pos unchanged, go to SETTLE.
//   - MOVE (1 cycle): move_o = command code, then go to SETTLE.
//   - SETTLE: move_o=000 for SETTLE_CYC cycles. Then:
//     - enable_i=0: stay in SETTLE (paused, motor on).
//     - count_o!=0: go to FETCH.
//     - otherwise: go to PWRDN.
//   - PWRDN: motor_on_o=0. Wait for motor_status_i=0, then go to IDLE. On PWR_TMO: set fault_o, go to IDLE.
//  Motor drop: motor_status_i=0 in FETCH, MOVE or SETTLE sets fault_o, flushes the FIFO, drops motor_on_o, and goes to IDLE.
//  Arithmetic:
//   - Heading: RIGHT = +1 mod 4, LEFT = -1 mod 4 (2-bit wrap).
//   - FWD deltas: W x-1, N y+1, E x+1, S y-1. BWD uses the opposite delta.
//   - Bounds are checked before the update, so pos never leaves 1..GRID.
//  Throughput: one command per 2+SETTLE_CYC cycles while the motor stays on.
// TESTING
//  T1: after reset, push FWD,FWD with motor_status following motor_on 2 cycles later
//      -> move_o=111 twice, each followed by 1 STAY cycle; pos (5,3); then motor_on_o=0 and IDLE.
//  T2: from (5,1) facing N, push LEFT,FWD,RIGHT,RIGHT
//      -> move_o 101,111,110,110; pos (4,1); heading 10.
//  T3: from (5,1) facing N, push BWD
//      -> blocked_o pulses, move_o stays 000, pos (5,1).
//      Then tracker_i=1 and push FWD -> blocked_o pulses.
//  T4: push DEPTH+1 commands while enable_i=0
//      -> cmd_ready_o low after the 8th push, count_o=8.
//      Raise enable_i -> all 8 commands execute in order.
//  T5: motor_status_i held 0 in PWRUP
//      -> fault_o=1 after 16 cycles, FIFO flushed, cmd_ready_o=0 until reset.
//  T6: assert rst_i during a MOVE cycle
//      -> move_o=000 and pos=(5,1) without waiting for a clock edge.

Source files
------------

// File: rtl/robot_route_sequencer.sv
// Command sequencer in front of the robot core: FIFO-buffered motion commands,
// motor power sequencing, grid/heading tracking and refusal of illegal moves.
module robot_route_sequencer #(
   parameter int DEPTH      = 8,
   parameter int GRID       = 7,
   parameter int X0         = 5,
   parameter int Y0         = 1,
   parameter int SETTLE_CYC = 1,
   parameter int PWR_TMO    = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         enable_i,
   input  logic                         cmd_valid_i,
   input  logic [1:0]                   cmd_i,
   output logic                         cmd_ready_o,
   output logic                         motor_on_o,
   input  logic                         motor_status_i,
   output logic [2:0]                   move_o,
   input  logic                         tracker_i,
   output logic [2:0]                   pos_x_o,
   output logic [2:0]                   pos_y_o,
   output logic [1:0]                   heading_o,
   output logic                         busy_o,
   output logic                         blocked_o,
   output logic                         fault_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(PWR_TMO + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [3:0]    GRID_C   = 4'(GRID);
   localparam logic [TW-1:0] TMO_LAST = TW'(PWR_TMO - 1);
   localparam logic [SW-1:0] STL_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [1:0] C_FWD = 2'b00, C_BWD = 2'b01, C_LEFT = 2'b10, C_RIGHT = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_PWRUP, S_FETCH, S_MOVE, S_SETTLE, S_PWRDN} state_e;

   function automatic logic [2:0] move_code(input logic [1:0] c);
      case (c)
         C_FWD:   move_code = 3'b111;
         C_BWD:   move_code = 3'b011;
         C_LEFT:  move_code = 3'b101;
         C_RIGHT: move_code = 3'b110;
         default: move_code = 3'b000;
      endcase
   endfunction

   state_e        state_q, state_d;
   logic [1:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [SW-1:0] stl_q, stl_d;
   logic [2:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d, move_q, move_d;
   logic [1:0]    hd_q, hd_d;
   logic          motor_on_q, motor_on_d, blocked_q, blocked_d, fault_q, fault_d;
   logic          busy_q, busy_d, ready_q, ready_d;
   logic          push_s, pop_s, flush_s, drop_s, in_grid_s, refuse_s;
   logic [1:0]    head_s;
   logic [3:0]    fdx_s, fdy_s, nx_s, ny_s;

   assign push_s = cmd_valid_i && ready_q;
   assign head_s = mem_q[rd_ptr_q];
   assign drop_s = !motor_status_i &&
                   ((state_q == S_FETCH) || (state_q == S_MOVE) || (state_q == S_SETTLE));

   // Target cell of the head command: forward delta, negated for BWD.
   always_comb begin
      fdx_s = 4'd0;
      fdy_s = 4'd0;
      case (hd_q)
         2'b00:   fdx_s = 4'hF;
         2'b01:   fdy_s = 4'd1;
         2'b10:   fdx_s = 4'd1;
         2'b11:   fdy_s = 4'hF;
         default: fdx_s = 4'd0;
      endcase
      nx_s = (head_s == C_BWD) ? ({1'b0, pos_x_q} - fdx_s) : ({1'b0, pos_x_q} + fdx_s);
      ny_s = (head_s == C_BWD) ? ({1'b0, pos_y_q} - fdy_s) : ({1'b0, pos_y_q} + fdy_s);
      in_grid_s = (nx_s >= 4'd1) && (nx_s <= GRID_C) && (ny_s >= 4'd1) && (ny_s <= GRID_C);
      refuse_s  = ((head_s == C_FWD) && (tracker_i || !in_grid_s)) ||
                  ((head_s == C_BWD) && !in_grid_s);
   end

   // Sequencer FSM: next state and registered-output next values.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      stl_d      = stl_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      hd_d       = hd_q;
      move_d     = 3'b000;
      motor_on_d = motor_on_q;
      blocked_d  = 1'b0;
      fault_d    = fault_q;
      pop_s      = 1'b0;
      flush_s    = 1'b0;
      if (drop_s) begin
         fault_d    = 1'b1;
         flush_s    = 1'b1;
         motor_on_d = 1'b0;
         state_d    = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable_i && (count_q != {CW{1'b0}})) begin
                  motor_on_d = 1'b1;
                  tmr_d      = {TW{1'b0}};
                  state_d    = S_PWRUP;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_PWRUP: begin
               if (motor_status_i) begin
                  state_d = S_FETCH;
               end else if (tmr_q == TMO_LAST) begin
                  fault_d    = 1'b1;
                  motor_on_d = 1'b0;
                  flush_s    = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
            S_FETCH: begin
               pop_s = 1'b1;
               stl_d = {SW{1'b0}};
               if (refuse_s) begin
                  blocked_d = 1'b1;
                  state_d   = S_SETTLE;
               end else begin
                  move_d  = move_code(head_s);
                  state_d = S_MOVE;
                  case (head_s)
                     C_LEFT:  hd_d = hd_q - 2'd1;
                     C_RIGHT: hd_d = hd_q + 2'd1;
                     default: begin
                        pos_x_d = nx_s[2:0];
                        pos_y_d = ny_s[2:0];
                     end
                  endcase
               end
            end
            S_MOVE: begin
               stl_d   = {SW{1'b0}};
               state_d = S_SETTLE;
            end
            S_SETTLE: begin
               if (stl_q != STL_LAST) begin
                  stl_d = stl_q + SW'(1);
               end else if (!enable_i) begin
                  state_d = S_SETTLE;
               end else if (count_q != {CW{1'b0}}) begin
                  state_d = S_FETCH;
               end else begin
                  motor_on_d = 1'b0;
                  tmr_d      = {TW{1'b0}};
                  state_d    = S_PWRDN;
               end
            end
            S_PWRDN: begin
               if (!motor_status_i) begin
                  state_d = S_IDLE;
               end else if (tmr_q == TMO_LAST) begin
                  fault_d = 1'b1;
                  flush_s = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FIFO pointers and occupancy; a flush wins over a simultaneous push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_s) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
         count_d  = count_q + CW'(push_s) - CW'(pop_s);
      end
      ready_d = (count_d < DEPTH_C) && !fault_d;
      busy_d  = (state_d != S_IDLE);
   end

   // FIFO storage needs no reset: pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= cmd_i;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         tmr_q      <= {TW{1'b0}};
         stl_q      <= {SW{1'b0}};
         pos_x_q    <= 3'(X0);
         pos_y_q    <= 3'(Y0);
         hd_q       <= 2'b01;
         move_q     <= 3'b000;
         motor_on_q <= 1'b0;
         blocked_q  <= 1'b0;
         fault_q    <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tmr_q      <= tmr_d;
         stl_q      <= stl_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         hd_q       <= hd_d;
         move_q     <= move_d;
         motor_on_q <= motor_on_d;
         blocked_q  <= blocked_d;
         fault_q    <= fault_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
      end
   end

   assign cmd_ready_o = ready_q;
   assign motor_on_o  = motor_on_q;
   assign move_o      = move_q;
   assign pos_x_o     = pos_x_q;
   assign pos_y_o     = pos_y_q;
   assign heading_o   = hd_q;
   assign busy_o      = busy_q;
   assign blocked_o   = blocked_q;
   assign fault_o     = fault_q;
   assign count_o     = count_q;
endmodule

// File: tb/tb_robot_route_sequencer.sv
// Directed bench for robot_route_sequencer: a per-command vector table plus
// hand-written sequences for throughput, FIFO full, power faults and reset.
module tb_robot_route_sequencer;
   logic       clk_i = 1'b0;
   logic       rst_i, enable_i, cmd_valid_i, tracker_i, motor_status_i;
   logic [1:0] cmd_i;
   logic       cmd_ready_o, motor_on_o, busy_o, blocked_o, fault_o;
   logic [2:0] move_o, pos_x_o, pos_y_o;
   logic [1:0] heading_o;
   logic [3:0] count_o;
   logic       d1, d2, stuck0;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [1:0] cmd;
      logic       trk;
      logic [2:0] mv;
      logic       blk;
      logic [2:0] x;
      logic [2:0] y;
      logic [1:0] hd;
   } vec_t;
   vec_t vt[19];
   logic [1:0] t4c[9];
   logic [2:0] t4m[8];

   robot_route_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .cmd_valid_i(cmd_valid_i),
      .cmd_i(cmd_i), .cmd_ready_o(cmd_ready_o), .motor_on_o(motor_on_o),
      .motor_status_i(motor_status_i), .move_o(move_o), .tracker_i(tracker_i),
      .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .heading_o(heading_o), .busy_o(busy_o),
      .blocked_o(blocked_o), .fault_o(fault_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // Robot motor model: status follows motor_on two cycles later unless stuck low.
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         d1 <= 1'b0;
         d2 <= 1'b0;
      end else begin
         d1 <= motor_on_o;
         d2 <= d1;
      end
   end
   assign motor_status_i = d2 && !stuck0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1; enable_i = 1'b0; cmd_valid_i = 1'b0; cmd_i = 2'b00;
      tracker_i = 1'b0; stuck0 = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic push(input logic [1:0] c);
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_i = c;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic push2(input logic [1:0] a, input logic [1:0] b);
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_i = a;
      @(negedge clk_i);
      cmd_i = b;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_event(input string nm);
      bit seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (move_o != 3'b000 || blocked_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk({nm, " event seen"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_idle(input string nm);
      for (int c = 0; c < 80; c++) begin
         @(negedge clk_i);
         if (!busy_o) break;
      end
      chk({nm, " idle"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      vt[0]  = '{2'b01, 1'b0, 3'b000, 1'b1, 3'd5, 3'd1, 2'b01};
      vt[1]  = '{2'b10, 1'b0, 3'b101, 1'b0, 3'd5, 3'd1, 2'b00};
      vt[2]  = '{2'b00, 1'b0, 3'b111, 1'b0, 3'd4, 3'd1, 2'b00};
      vt[3]  = '{2'b11, 1'b0, 3'b110, 1'b0, 3'd4, 3'd1, 2'b01};
      vt[4]  = '{2'b11, 1'b0, 3'b110, 1'b0, 3'd4, 3'd1, 2'b10};
      vt[5]  = '{2'b00, 1'b1, 3'b000, 1'b1, 3'd4, 3'd1, 2'b10};
      vt[6]  = '{2'b00, 1'b0, 3'b111, 1'b0, 3'd5, 3'd1, 2'b10};
      vt[7]  = '{2'b00, 1'b0, 3'b111, 1'b0, 3'd6, 3'd1, 2'b10};
      vt[8]  = '{2'b00, 1'b0, 3'b111, 1'b0, 3'd7, 3'd1, 2'b10};
      vt[9]  = '{2'b00, 1'b0, 3'b000, 1'b1, 3'd7, 3'd1, 2'b10};
      vt[10] = '{2'b01, 1'b1, 3'b011, 1'b0, 3'd6, 3'd1, 2'b10};
      vt[11] = '{2'b10, 1'b1, 3'b101, 1'b0, 3'd6, 3'd1, 2'b01};
      vt[12] = '{2'b10, 1'b0, 3'b101, 1'b0, 3'd6, 3'd1, 2'b00};
      vt[13] = '{2'b10, 1'b0, 3'b101, 1'b0, 3'd6, 3'd1, 2'b11};
      vt[14] = '{2'b00, 1'b0, 3'b000, 1'b1, 3'd6, 3'd1, 2'b11};
      vt[15] = '{2'b11, 1'b0, 3'b110, 1'b0, 3'd6, 3'd1, 2'b00};
      vt[16] = '{2'b11, 1'b0, 3'b110, 1'b0, 3'd6, 3'd1, 2'b01};
      vt[17] = '{2'b00, 1'b0, 3'b111, 1'b0, 3'd6, 3'd2, 2'b01};
      vt[18] = '{2'b01, 1'b0, 3'b011, 1'b0, 3'd6, 3'd1, 2'b01};
      t4c = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
      t4m = '{3'b110, 3'b011, 3'b101, 3'b111, 3'b111, 3'b101, 3'b111, 3'b110};

      // Reset state
      do_reset();
      @(negedge clk_i);
      chk("rst move", 32'(move_o), 32'd0);
      chk("rst motor_on", 32'(motor_on_o), 32'd0);
      chk("rst blocked", 32'(blocked_o), 32'd0);
      chk("rst fault", 32'(fault_o), 32'd0);
      chk("rst busy", 32'(busy_o), 32'd0);
      chk("rst count", 32'(count_o), 32'd0);
      chk("rst ready", 32'(cmd_ready_o), 32'd1);
      chk("rst x", 32'(pos_x_o), 32'd5);
      chk("rst y", 32'(pos_y_o), 32'd1);
      chk("rst heading", 32'(heading_o), 32'd1);

      // Vector table: one command per power cycle
      enable_i = 1'b1;
      for (int i = 0; i < 19; i++) begin
         tracker_i = vt[i].trk;
         push(vt[i].cmd);
         wait_event($sformatf("v%0d", i));
         chk($sformatf("v%0d move", i), 32'(move_o), 32'(vt[i].mv));
         chk($sformatf("v%0d blocked", i), 32'(blocked_o), 32'(vt[i].blk));
         chk($sformatf("v%0d x", i), 32'(pos_x_o), 32'(vt[i].x));
         chk($sformatf("v%0d y", i), 32'(pos_y_o), 32'(vt[i].y));
         chk($sformatf("v%0d heading", i), 32'(heading_o), 32'(vt[i].hd));
         wait_idle($sformatf("v%0d", i));
      end
      tracker_i = 1'b0;

      // T1: back-to-back FWD,FWD at full throughput
      do_reset();
      enable_i = 1'b1;
      push2(2'b00, 2'b00);
      wait_event("t1");
      chk("t1 move1", 32'(move_o), 32'b111);
      @(negedge clk_i);
      chk("t1 stay", 32'(move_o), 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("t1 move2", 32'(move_o), 32'b111);
      wait_idle("t1");
      chk("t1 motor_on", 32'(motor_on_o), 32'd0);
      chk("t1 x", 32'(pos_x_o), 32'd5);
      chk("t1 y", 32'(pos_y_o), 32'd3);

      // T4: fill FIFO while paused, overflow push refused, then drain in order
      do_reset();
      @(negedge clk_i);
      cmd_valid_i = 1'b1;
      for (int k = 0; k < 9; k++) begin
         cmd_i = t4c[k];
         @(negedge clk_i);
         if (k == 7) begin
            chk("t4 count full", 32'(count_o), 32'd8);
            chk("t4 ready full", 32'(cmd_ready_o), 32'd0);
         end
      end
      cmd_valid_i = 1'b0;
      chk("t4 count after overflow", 32'(count_o), 32'd8);
      enable_i = 1'b1;
      begin
         int k = 0;
         for (int c = 0; c < 300 && k < 8; c++) begin
            @(negedge clk_i);
            if (move_o != 3'b000) begin
               chk($sformatf("t4 move%0d", k), 32'(move_o), 32'(t4m[k]));
               k++;
            end
         end
         chk("t4 moves seen", 32'(k), 32'd8);
      end
      wait_idle("t4");
      chk("t4 x", 32'(pos_x_o), 32'd3);
      chk("t4 y", 32'(pos_y_o), 32'd3);
      chk("t4 heading", 32'(heading_o), 32'd1);
      chk("t4 count", 32'(count_o), 32'd0);

      // T5: motor never reports on -> fault after PWR_TMO cycles in PWRUP
      do_reset();
      stuck0 = 1'b1;
      enable_i = 1'b1;
      push(2'b00);
      for (int c = 0; c < 10; c++) begin
         if (motor_on_o) break;
         @(negedge clk_i);
      end
      chk("t5 motor_on", 32'(motor_on_o), 32'd1);
      repeat (15) @(negedge clk_i);
      chk("t5 fault early", 32'(fault_o), 32'd0);
      @(negedge clk_i);
      chk("t5 fault", 32'(fault_o), 32'd1);
      chk("t5 motor_off", 32'(motor_on_o), 32'd0);
      chk("t5 count", 32'(count_o), 32'd0);
      chk("t5 ready", 32'(cmd_ready_o), 32'd0);
      push(2'b00);
      @(negedge clk_i);
      chk("t5 count after push", 32'(count_o), 32'd0);
      chk("t5 fault sticky", 32'(fault_o), 32'd1);

      // Motor drop during MOVE -> fault, flush, back to IDLE
      do_reset();
      enable_i = 1'b1;
      push2(2'b00, 2'b00);
      wait_event("drop");
      stuck0 = 1'b1;
      @(negedge clk_i);
      chk("drop fault", 32'(fault_o), 32'd1);
      chk("drop count", 32'(count_o), 32'd0);
      chk("drop motor_on", 32'(motor_on_o), 32'd0);
      chk("drop busy", 32'(busy_o), 32'd0);

      // T6: asynchronous reset during a MOVE cycle
      do_reset();
      enable_i = 1'b1;
      push(2'b00);
      wait_event("t6");
      chk("t6 move before", 32'(move_o), 32'b111);
      #2 rst_i = 1'b1;
      #1;
      chk("t6 move", 32'(move_o), 32'd0);
      chk("t6 x", 32'(pos_x_o), 32'd5);
      chk("t6 y", 32'(pos_y_o), 32'd1);
      chk("t6 heading", 32'(heading_o), 32'd1);
      chk("t6 motor_on", 32'(motor_on_o), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
